seven_sd_capture: RTL and testbench

- Receive-side counterpart of the seven-segment signal generator.
- Passively samples a multiplexed seven-segment bus (8 segment lines, 4 digit enables) and rebuilds the 32-bit display value, one byte per digit.
- Used as a loopback checker on the tester board, and to capture another board's display through the Pmod header.
- Publishes the value only after all four digits have been seen stable within one frame.

---
 rtl/seven_sd_pkg.sv | 30 +++
 rtl/seven_sd_capture_if.sv | 26 ++
 rtl/seven_sd_input_sync.sv | 32 +++
 rtl/seven_sd_capture.sv | 198 +++++++++++++++++++
 tb/tb_seven_sd_capture.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seven_sd_pkg.sv
// Shared definitions for the seven-segment bus capture block.
//   DIGITS / SEG_W : bus geometry (4 digit enables, 8 segment lines)
//   state_t        : capture FSM states
//   onehot4()      : classifies a normalised enable vector
package seven_sd_pkg;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } state_t;

    // Returns {valid, index[1:0], bad}. All-zero input is blank (neither valid nor bad).
    function automatic logic [3:0] onehot4(input logic [3:0] en);
        logic [3:0] r;
        case (en)
            4'b0001: r = 4'b1_00_0;
            4'b0010: r = 4'b1_01_0;
            4'b0100: r = 4'b1_10_0;
            4'b1000: r = 4'b1_11_0;
            4'b0000: r = 4'b0_00_0;
            default: r = 4'b0_00_1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_sd_capture_if.sv
// Bus bundle for seven_sd_capture.
//   displayIn / enableIn : raw multiplexed display pins (driven by master)
//   value, valueValid, frameStrobe, digitMask, badEnable, stale : capture results
interface seven_sd_capture_if;
    import seven_sd_pkg::*;

    logic [SEG_W-1:0]        displayIn;
    logic [DIGITS-1:0]       enableIn;
    logic [DIGITS*SEG_W-1:0] value;
    logic                    valueValid;
    logic                    frameStrobe;
    logic [DIGITS-1:0]       digitMask;
    logic                    badEnable;
    logic                    stale;

    modport master (
        output displayIn, enableIn,
        input  value, valueValid, frameStrobe, digitMask, badEnable, stale
    );

    modport slave (
        input  displayIn, enableIn,
        output value, valueValid, frameStrobe, digitMask, badEnable, stale
    );

endinterface

// File: rtl/seven_sd_input_sync.sv
// Two-flop synchronizer for an asynchronous bus.
//   clk, rstN : clock, async active-low reset
//   d_i       : asynchronous input bus
//   q_o       : synchronized bus, two cycles behind d_i
// RST_VAL lets the caller reset the chain to the pins' inactive level, so a
// freshly released block does not see a spurious pattern.
module seven_sd_input_sync #(
    parameter int               WIDTH   = 12,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/seven_sd_capture.sv
// Passive capture of a multiplexed seven-segment bus; rebuilds the 32-bit
// display value (one active-high byte per digit) once all four digits have
// been seen stable within one frame.
//   clk, rstN : clock, async active-low reset
//   bus       : slave side of seven_sd_capture_if (pins in, results out)
//
//   state    | meaning
//   IDLE     | enables blank (or just left a bad pattern), nothing tracked
//   SETTLE   | one digit enabled, counting consecutive stable cycles
//   CAPTURED | digit byte latched, waiting for the enables to move on
module seven_sd_capture
    import seven_sd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rstN,
    seven_sd_capture_if.slave bus
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DIGITS-1:0] EN_INV  = {DIGITS{EN_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]  SEG_INV = {SEG_W{SEG_ACTIVE_LOW}};

    logic [DIGITS+SEG_W-1:0] sync_bus;
    logic [DIGITS-1:0]       en_n;
    logic [SEG_W-1:0]        seg_n;
    logic [3:0]              cls;
    logic                    en_valid, en_bad, en_blank;
    logic [1:0]              en_idx;

    // Synchronizer resets to the pins' inactive level (blank, all segments off).
    seven_sd_input_sync #(
        .WIDTH   (DIGITS + SEG_W),
        .RST_VAL ({EN_INV, SEG_INV})
    ) u_sync (
        .clk  (clk),
        .rstN (rstN),
        .d_i  ({bus.enableIn, bus.displayIn}),
        .q_o  (sync_bus)
    );

    assign en_n     = sync_bus[DIGITS+SEG_W-1:SEG_W] ^ EN_INV;
    assign seg_n    = sync_bus[SEG_W-1:0] ^ SEG_INV;
    assign cls      = onehot4(en_n);
    assign en_valid = cls[3];
    assign en_idx   = cls[2:1];
    assign en_bad   = cls[0];
    assign en_blank = (en_n == '0);

    state_t                         state_q, state_d;
    logic [DIGITS-1:0]              rec_en_q, rec_en_d;
    logic [SEG_W-1:0]               rec_seg_q, rec_seg_d;
    logic [1:0]                     rec_idx_q, rec_idx_d;
    logic [SET_W-1:0]               settle_q, settle_d;
    logic [TO_W-1:0]                to_q, to_d;
    logic [DIGITS-1:0][SEG_W-1:0]   shadow_q, shadow_d;
    logic [DIGITS-1:0]              mask_q, mask_d;
    logic [DIGITS*SEG_W-1:0]        value_q, value_d;
    logic                           valid_q, valid_d;
    logic                           strobe_q, strobe_d;
    logic                           bad_q, bad_d;
    logic                           bad_prev_q, bad_prev_d;
    logic                           stale_q, stale_d;
    logic                           latch;
    logic [DIGITS-1:0]              mask_set;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            rec_en_q   <= '0;
            rec_seg_q  <= '0;
            rec_idx_q  <= '0;
            settle_q   <= '0;
            to_q       <= '0;
            shadow_q   <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            bad_q      <= 1'b0;
            bad_prev_q <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rec_en_q   <= rec_en_d;
            rec_seg_q  <= rec_seg_d;
            rec_idx_q  <= rec_idx_d;
            settle_q   <= settle_d;
            to_q       <= to_d;
            shadow_q   <= shadow_d;
            mask_q     <= mask_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            bad_q      <= bad_d;
            bad_prev_q <= bad_prev_d;
            stale_q    <= stale_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rec_en_d   = rec_en_q;
        rec_seg_d  = rec_seg_q;
        rec_idx_d  = rec_idx_q;
        settle_d   = settle_q;
        to_d       = to_q;
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        value_d    = value_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        bad_d      = 1'b0;
        bad_prev_d = en_bad;
        stale_d    = stale_q;
        latch      = 1'b0;
        mask_set   = '0;

        if (en_bad) begin
            // Pulse once per bad episode, not on every cycle it persists.
            bad_d   = !bad_prev_q;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_valid) begin
                        state_d   = SETTLE;
                        settle_d  = '0;
                        rec_en_d  = en_n;
                        rec_seg_d = seg_n;
                        rec_idx_d = en_idx;
                    end
                end
                SETTLE: begin
                    if ({en_n, seg_n} != {rec_en_q, rec_seg_q}) begin
                        settle_d  = '0;
                        rec_en_d  = en_n;
                        rec_seg_d = seg_n;
                        rec_idx_d = en_idx;
                        if (en_blank) state_d = IDLE;
                    end else if (settle_q == SET_LAST) begin
                        latch   = 1'b1;
                        state_d = CAPTURED;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                CAPTURED: begin
                    if (en_n != rec_en_q) begin
                        settle_d  = '0;
                        rec_en_d  = en_n;
                        rec_seg_d = seg_n;
                        rec_idx_d = en_idx;
                        state_d   = en_blank ? IDLE : SETTLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A latch always beats a coincident timeout.
        if (latch) begin
            to_d                = '0;
            shadow_d[rec_idx_q] = rec_seg_q;
            mask_set            = mask_q | (DIGITS'(1) << rec_idx_q);
            if (mask_set == '1) begin
                value_d  = shadow_d;
                strobe_d = 1'b1;
                valid_d  = 1'b1;
                stale_d  = 1'b0;
                mask_d   = '0;
            end else begin
                mask_d   = mask_set;
            end
        end else if (to_q == TO_LAST) begin
            stale_d = 1'b1;
            valid_d = 1'b0;
            mask_d  = '0;
        end else begin
            to_d = to_q + TO_W'(1);
        end
    end

    assign bus.value       = value_q;
    assign bus.valueValid  = valid_q;
    assign bus.frameStrobe = strobe_q;
    assign bus.digitMask   = mask_q;
    assign bus.badEnable   = bad_q;
    assign bus.stale       = stale_q;

endmodule

// File: tb/tb_seven_sd_capture.sv
module tb_seven_sd_capture;

    localparam int SETTLE = 16;
    localparam int TMO    = 1000;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    seven_sd_capture_if bus();

    seven_sd_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO),
        .SEG_ACTIVE_LOW (1'b1),
        .EN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int strobes = 0;
    int bads    = 0;

    // Event counters sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.frameStrobe === 1'b1) strobes++;
        if (bus.badEnable === 1'b1) bads++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pins are changed on the falling edge and held for n cycles.
    task automatic hold(input logic [3:0] en, input logic [7:0] seg, input int n);
        bus.enableIn  = en;
        bus.displayIn = seg;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] dig(input int k);
        logic [3:0] one;
        one = 4'b0001 << k;
        return ~one;
    endfunction

    // Reference model state for the randomized section.
    logic [3:0][7:0] m_sh;
    logic [3:0]      m_mask;
    logic [31:0]     m_value;
    int              exp_strobes = 0;
    int              since;

    initial begin
        bus.enableIn  = 4'hF;
        bus.displayIn = 8'hFF;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_value", bus.value, 32'h0);
        chk("rst_valid", 32'(bus.valueValid), 32'h0);
        chk("rst_mask", 32'(bus.digitMask), 32'h0);
        chk("rst_stale", 32'(bus.stale), 32'h0);
        rstN = 1'b1;
        @(negedge clk);

        // Basic frame with latch-timing boundary on digit 0.
        hold(dig(0), ~8'h3F, 18);
        chk("d0_before_latch", 32'(bus.digitMask), 32'h0);
        hold(dig(0), ~8'h3F, 1);
        chk("d0_latch_edge", 32'(bus.digitMask), 32'h1);
        hold(dig(0), ~8'h3F, 81);
        hold(dig(1), ~8'h06, 100);
        hold(dig(2), ~8'h5B, 100);
        chk("mask_0111", 32'(bus.digitMask), 32'h7);
        hold(dig(3), ~8'h4F, 100);
        exp_strobes++;
        chk("frame1_value", bus.value, 32'h4F5B063F);
        chk("frame1_valid", 32'(bus.valueValid), 32'h1);
        chk("frame1_mask", 32'(bus.digitMask), 32'h0);
        chk("frame1_strobes", 32'(strobes), 32'(exp_strobes));

        // Short glitch on digit 0 must not latch.
        hold(dig(0), ~8'h77, 10);
        chk("glitch_mask", 32'(bus.digitMask), 32'h0);
        hold(dig(0), ~8'h66, 100);
        hold(dig(1), ~8'h6D, 100);
        hold(dig(2), ~8'h7D, 100);
        hold(dig(3), ~8'h07, 100);
        exp_strobes++;
        chk("frame2_value", bus.value, 32'h077D6D66);
        chk("frame2_strobes", 32'(strobes), 32'(exp_strobes));

        // Segment change mid-settle restarts the count.
        hold(dig(0), ~8'h06, 100);
        hold(dig(1), ~8'h5B, 100);
        hold(dig(2), ~8'h4F, 8);
        hold(dig(2), ~8'h66, 18);
        chk("segchg_before", 32'(bus.digitMask), 32'h3);
        hold(dig(2), ~8'h66, 1);
        chk("segchg_latch", 32'(bus.digitMask), 32'h7);
        hold(dig(2), ~8'h66, 20);
        hold(dig(3), ~8'h7D, 100);
        exp_strobes++;
        chk("frame3_value", bus.value, 32'h7D665B06);
        chk("frame3_strobes", 32'(strobes), 32'(exp_strobes));

        // Bad enable pattern mid-frame.
        hold(dig(0), ~8'h3F, 100);
        hold(dig(1), ~8'h06, 100);
        hold(4'b1100, 8'hFF, 5);
        hold(4'b1111, 8'hFF, 3);
        chk("bad_pulses", 32'(bads), 32'h1);
        chk("bad_mask_kept", 32'(bus.digitMask), 32'h3);
        hold(dig(2), ~8'h5B, 100);
        hold(dig(3), ~8'h4F, 100);
        exp_strobes++;
        chk("frame4_value", bus.value, 32'h4F5B063F);
        chk("frame4_strobes", 32'(strobes), 32'(exp_strobes));
        chk("bad_total", 32'(bads), 32'h1);

        // Timeout: one digit captured, then blank until stale.
        hold(dig(0), ~8'h3F, 100);
        chk("tmo_partial", 32'(bus.digitMask), 32'h1);
        hold(4'b1111, 8'hFF, 918);
        chk("tmo_not_yet", 32'(bus.stale), 32'h0);
        hold(4'b1111, 8'hFF, 1);
        chk("tmo_stale", 32'(bus.stale), 32'h1);
        chk("tmo_invalid", 32'(bus.valueValid), 32'h0);
        chk("tmo_mask_clr", 32'(bus.digitMask), 32'h0);
        hold(4'b1111, 8'hFF, 100);
        chk("tmo_value_held", bus.value, 32'h4F5B063F);
        hold(dig(0), ~8'h5B, 100);
        hold(dig(1), ~8'h4F, 100);
        hold(dig(2), ~8'h3F, 100);
        chk("tmo_still_stale", 32'(bus.stale), 32'h1);
        hold(dig(3), ~8'h06, 100);
        exp_strobes++;
        chk("tmo_recover_value", bus.value, 32'h063F4F5B);
        chk("tmo_recover_stale", 32'(bus.stale), 32'h0);
        chk("tmo_recover_valid", 32'(bus.valueValid), 32'h1);

        // Randomized digit sequences against a digit/mask model.
        m_sh    = 32'h063F4F5B;
        m_mask  = 4'h0;
        m_value = 32'h063F4F5B;
        since   = 100;
        for (int f = 0; f < 4; f++) begin
            int steps = 0;
            int start = exp_strobes;
            while (exp_strobes == start && steps < 40) begin
                int k;
                int n;
                logic [7:0] b;
                logic lng;
                k   = $urandom_range(0, 3);
                b   = 8'($urandom);
                lng = ($urandom_range(0, 2) != 0) || (since > 600);
                n   = lng ? $urandom_range(30, 60) : $urandom_range(3, 10);
                hold(dig(k), b, n);
                hold(4'b1111, 8'($urandom), 2);
                since += n + 2;
                if (lng) begin
                    since   = 0;
                    m_sh[k] = ~b;
                    m_mask  = m_mask | (4'b0001 << k);
                    if (m_mask == 4'hF) begin
                        m_value = m_sh;
                        m_mask  = 4'h0;
                        exp_strobes++;
                    end
                end
                chk("rnd_mask", 32'(bus.digitMask), 32'(m_mask));
                steps++;
            end
            chk("rnd_value", bus.value, m_value);
            chk("rnd_strobes", 32'(strobes), 32'(exp_strobes));
        end
        chk("rnd_no_bad", 32'(bads), 32'h1);

        // Asynchronous reset mid-frame discards the partial frame.
        hold(dig(0), ~8'h3F, 100);
        hold(dig(1), ~8'h06, 100);
        chk("pre_rst_mask", 32'(bus.digitMask), 32'h3);
        bus.enableIn  = 4'hF;
        bus.displayIn = 8'hFF;
        #3;
        rstN = 1'b0;
        #1;
        chk("arst_value", bus.value, 32'h0);
        chk("arst_valid", 32'(bus.valueValid), 32'h0);
        chk("arst_mask", 32'(bus.digitMask), 32'h0);
        chk("arst_pulses", 32'({bus.frameStrobe, bus.badEnable, bus.stale}), 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        hold(4'b1111, 8'hFF, 3);
        hold(dig(2), ~8'h5B, 100);
        hold(dig(3), ~8'h4F, 100);
        chk("post_rst_strobes", 32'(strobes), 32'(exp_strobes));
        chk("post_rst_mask", 32'(bus.digitMask), 32'hC);
        chk("post_rst_valid", 32'(bus.valueValid), 32'h0);
        chk("post_rst_value", bus.value, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
